// File: rtl/drv_seg_sequencer_if.sv
// Handshake bundle for the segmented output-driver sequencer.
//   EN       : drive request (1 = ramp to target, 0 = ramp to off)
//   TGT      : requested segment count 0..7, saturating at 4
//   STEP_DLY : step interval minus one, in clock cycles
//   SEG_EN   : thermometer enables for four buffer segments
//   READY    : level equals target
//   DONE     : one-cycle pulse when a step lands on the target
//   BUSY     : level is moving
interface drv_seg_sequencer_if;
  logic       EN;
  logic [2:0] TGT;
  logic [3:0] STEP_DLY;
  logic [3:0] SEG_EN;
  logic       READY;
  logic       DONE;
  logic       BUSY;

  modport master (
    output EN, TGT, STEP_DLY,
    input  SEG_EN, READY, DONE, BUSY
  );

  modport slave (
    input  EN, TGT, STEP_DLY,
    output SEG_EN, READY, DONE, BUSY
  );
endinterface

// File: rtl/drv_seg_sequencer.sv
// Segmented output-driver sequencer. Ramps a 0..4 segment level toward the
// requested target one segment at a time, spacing steps STEP_DLY+1 cycles apart.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   bus : slave side of drv_seg_sequencer_if (EN/TGT/STEP_DLY in,
//         SEG_EN/READY/DONE/BUSY out, all outputs registered)
module drv_seg_sequencer (
  input logic                  CLK,
  input logic                  RST,
  drv_seg_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StUp, StDown, StHold} state_e;

  state_e     state_q;
  logic [2:0] lvl_q;
  logic [3:0] cnt_q;
  logic [3:0] seg_en_q;
  logic       ready_q;
  logic       done_q;
  logic       busy_q;

  logic [2:0] tgt;
  logic       dir_up;
  logic       dir_dn;
  logic       reversal;
  logic [3:0] cnt_eff;
  logic       do_step;
  logic [2:0] lvl_d;
  logic [3:0] cnt_d;
  state_e     state_d;

  function automatic logic [3:0] therm(input logic [2:0] l);
    logic [3:0] t;
    t = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (l > 3'(i)) t[i] = 1'b1;
    end
    return t;
  endfunction

  always_comb begin
    tgt      = 3'd0;
    if (bus.EN) tgt = (bus.TGT > 3'd4) ? 3'd4 : bus.TGT;

    dir_up   = lvl_q < tgt;
    dir_dn   = lvl_q > tgt;
    // state_q holds the direction left by the previous edge; an opposite
    // request restarts the interval from zero instead of using the old count.
    reversal = (dir_up && state_q == StDown) || (dir_dn && state_q == StUp);
    cnt_eff  = reversal ? 4'd0 : cnt_q;
    do_step  = (dir_up || dir_dn) && (cnt_eff >= bus.STEP_DLY);

    lvl_d = lvl_q;
    if (do_step) lvl_d = dir_up ? 3'(lvl_q + 3'd1) : 3'(lvl_q - 3'd1);

    if (!(dir_up || dir_dn) || do_step) cnt_d = 4'd0;
    else                                cnt_d = 4'(cnt_eff + 4'd1);

    if (lvl_d == tgt)     state_d = (tgt == 3'd0) ? StIdle : StHold;
    else if (lvl_d < tgt) state_d = StUp;
    else                  state_d = StDown;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      lvl_q    <= 3'd0;
      cnt_q    <= 4'd0;
      seg_en_q <= 4'b0000;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      seg_en_q <= therm(lvl_d);
      ready_q  <= (lvl_d == tgt);
      // Only a step can raise DONE; a target moving onto the level does not.
      done_q   <= do_step && (lvl_d == tgt);
      busy_q   <= (lvl_d != tgt);
    end
  end

  assign bus.SEG_EN = seg_en_q;
  assign bus.READY  = ready_q;
  assign bus.DONE   = done_q;
  assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_drv_seg_sequencer.sv
module tb_drv_seg_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drv_seg_sequencer_if bus ();

  drv_seg_sequencer dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] seg;
    logic       ready;
    logic       done;
    logic       busy;
    logic       rst;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: segment count, cycles waited toward target, last direction.
  int   m_l   = 0;
  int   m_cnt = 0;
  int   m_dir = 0;
  int   m_steps = 0;

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : (v < 0) ? -1 : 0;
  endfunction

  // Apply inputs for one edge, predict the outputs after it, then let the edge pass.
  task automatic cyc(input logic r, input logic en, input int tgt, input int dly,
                     input string tag);
    exp_t e;
    int   t;
    int   want;
    int   eff;
    bit   stepped;
    rst          = r;
    bus.EN       = en;
    bus.TGT      = 3'(tgt);
    bus.STEP_DLY = 4'(dly);
    stepped      = 0;
    if (r) begin
      m_l = 0; m_cnt = 0; m_dir = 0; t = 0;
    end else begin
      t    = en ? ((tgt > 4) ? 4 : tgt) : 0;
      want = sgn(t - m_l);
      eff  = (want != 0 && m_dir == -want) ? 0 : m_cnt;
      if (want == 0) m_cnt = 0;
      else if (eff >= dly) begin
        m_l += want; m_cnt = 0; stepped = 1; m_steps++;
      end else m_cnt = eff + 1;
      m_dir = sgn(t - m_l);
    end
    e.seg   = 4'((1 << m_l) - 1);
    e.ready = (m_l == t);
    e.done  = stepped && (m_l == t);
    e.busy  = (m_l != t);
    e.rst   = r;
    e.tag   = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic en, input int tgt, input int dly,
                     input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, en, tgt, dly, tag);
  endtask

  // Monitor: one expected entry per edge, compared away from the active edge.
  logic [3:0] prev_seg = 4'b0000;
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (bus.SEG_EN !== e.seg || bus.READY !== e.ready || bus.DONE !== e.done ||
          bus.BUSY !== e.busy) begin
        n_fail++;
        $display("FAIL %s: got seg=%b rdy=%b done=%b busy=%b, want seg=%b rdy=%b done=%b busy=%b",
                 e.tag, bus.SEG_EN, bus.READY, bus.DONE, bus.BUSY,
                 e.seg, e.ready, e.done, e.busy);
      end
      n_tests++;
      d = $countones(bus.SEG_EN) - $countones(prev_seg);
      if (!(bus.SEG_EN inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111}) ||
          (!e.rst && (d > 1 || d < -1))) begin
        n_fail++;
        $display("FAIL %s_thermo: got seg=%b after %b, want valid code with |dL|<=1",
                 e.tag, bus.SEG_EN, prev_seg);
      end
      prev_seg = bus.SEG_EN;
    end
  end

  initial begin
    int en_r, tgt_r, dly_r, len;
    bus.EN = 1'b0; bus.TGT = 3'd0; bus.STEP_DLY = 4'd0;

    cyc(1'b1, 1'b1, 4, 0, "reset");
    cyc(1'b1, 1'b1, 4, 0, "reset_over_en");
    run(6, 1'b1, 4, 0, "ramp4_dly0");

    cyc(1'b1, 1'b0, 0, 0, "reset");
    run(12, 1'b1, 3, 2, "ramp3_dly2");

    cyc(1'b1, 1'b0, 0, 0, "reset");
    run(5, 1'b1, 4, 0, "hold4");
    run(10, 1'b0, 4, 1, "ramp_down_dly1");

    cyc(1'b1, 1'b0, 0, 0, "reset");
    run(10, 1'b1, 4, 3, "up_dly3");
    run(12, 1'b0, 4, 3, "reverse_dly3");

    cyc(1'b1, 1'b0, 0, 0, "reset");
    run(6, 1'b1, 6, 0, "tgt_sat");
    run(6, 1'b1, 0, 1, "tgt0_en1");
    run(4, 1'b1, 2, 0, "up_to2");
    run(3, 1'b1, 2, 0, "hold2");
    run(8, 1'b1, 4, 2, "hold_retarget");
    run(3, 1'b1, 3, 15, "dly_high");
    run(2, 1'b1, 1, 15, "dly_hold");
    run(2, 1'b1, 1, 0, "dly_lowered");
    run(3, 1'b1, 1, 0, "tgt_eq_l");

    cyc(1'b1, 1'b0, 0, 0, "reset");
    run(3, 1'b1, 4, 0, "to_l3");
    cyc(1'b1, 1'b1, 4, 0, "reset_mid_ramp");
    run(3, 1'b1, 4, 0, "after_reset");

    for (int k = 0; k < 60; k++) begin
      en_r  = ($urandom_range(0, 4) != 0) ? 1 : 0;
      tgt_r = $urandom_range(0, 7);
      dly_r = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      len   = $urandom_range(1, 12);
      if ($urandom_range(0, 15) == 0) cyc(1'b1, en_r[0], tgt_r, dly_r, "rand_reset");
      run(len, en_r[0], tgt_r, dly_r, "random");
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    n_tests++;
    if (m_steps < 20) begin
      n_fail++;
      $display("FAIL activity: got %0d model steps, want at least 20", m_steps);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
